// File: rtl/ym_bus_pkg.sv
// Shared constants for the YM/AY bus controller: port decode patterns,
// TurboSound select base and the {bdir,bc1} bus-control encodings.
package ym_bus_pkg;

  // Low address nibble patterns (a3..a0)
  localparam logic [3:0] AY_LOW_MATCH = 4'b1101;
  localparam logic [3:0] FE_LOW_MATCH = 4'b1110;
  localparam logic [3:0] FB_LOW_MATCH = 4'b1011;

  localparam logic [7:0] TS_SEL_BASE = 8'hFF;

  // {bdir, bc1}
  localparam logic [1:0] BUS_INACTIVE = 2'b00;
  localparam logic [1:0] BUS_READ     = 2'b01;
  localparam logic [1:0] BUS_WRITE    = 2'b10;
  localparam logic [1:0] BUS_ADDR     = 2'b11;

  function automatic logic is_ay_port(input logic [15:0] a);
    return a[15] && (a[3:0] == AY_LOW_MATCH);
  endfunction

endpackage

// File: rtl/ym_clk_detect.sv
// Frame-length CPU clock detector: counts cpu_clock cycles between int_n
// falling edges and flips clk_is_7m after two agreeing measurements.
module ym_clk_detect
  import ym_bus_pkg::*;
#(
  parameter int unsigned DETECT_THRESH = 105000,
  parameter int unsigned CNT_W         = 18
) (
  input  logic cpu_clock,
  input  logic reset,
  input  logic int_n,
  output logic clk_is_7m
);

  logic             int_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             armed;
  logic             meas_valid;
  logic             meas_last;
  logic             int_fall;
  logic             meas;

  assign int_fall = int_q && !int_n;
  assign meas     = (frame_cnt >= CNT_W'(DETECT_THRESH));

  // Tracks int_n even in reset so a line already low at release is no edge.
  always_ff @(posedge cpu_clock) int_q <= int_n;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      frame_cnt  <= '0;
      armed      <= 1'b0;
      meas_valid <= 1'b0;
      meas_last  <= 1'b0;
      clk_is_7m  <= 1'b0;
    end else if (int_fall) begin
      frame_cnt <= '0;
      armed     <= 1'b1;
      if (armed) begin
        meas_last  <= meas;
        meas_valid <= 1'b1;
        if (meas_valid && (meas_last == meas) && (meas != clk_is_7m))
          clk_is_7m <= meas;
      end
    end else if (frame_cnt != '1) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ym_bus_ctrl.sv
// CPLD bus controller for up to four AY/YM chips (TurboSound select), with
// IORQGE, #FE beeper/tape latch, #FB covox latch and 3.5/7 MHz chip clock.
module ym_bus_ctrl
  import ym_bus_pkg::*;
#(
  parameter int unsigned NUM_CHIPS     = 2,
  parameter int unsigned DETECT_THRESH = 105000,
  parameter int unsigned CNT_W         = 18
) (
  input  logic                 cpu_clock,
  input  logic                 reset,
  input  logic [15:0]          addr,
  input  logic [7:0]           d,
  input  logic                 iorq_n,
  input  logic                 wr_n,
  input  logic                 rd_n,
  input  logic                 m1_n,
  input  logic                 int_n,
  output logic                 bdir,
  output logic                 bc1,
  output logic [NUM_CHIPS-1:0] ym_sel_n,
  output logic                 ym_clock,
  output logic                 clk_is_7m,
  output logic                 ioge,
  output logic                 beeper,
  output logic                 tapeout,
  output logic [7:0]           covox_data,
  output logic                 covox_strobe
);

  logic       io_wr, io_rd, io_wr_q, wr_event;
  logic       ay_port, is_fffd, is_bffd, is_fe, is_fb;
  logic [7:0] sel_k;
  logic       sel_hit;
  logic [1:0] bus_next;
  logic       div_q, sel_7m;
  logic       unused_addr;

  assign unused_addr = ^addr[12:4];

  assign io_wr = !iorq_n && !wr_n && m1_n;
  assign io_rd = !iorq_n && !rd_n && m1_n;

  assign ay_port = is_ay_port(addr);
  assign is_fffd = ay_port && addr[14];
  assign is_bffd = ay_port && !addr[14];
  assign is_fe   = (addr[3:0] == FE_LOW_MATCH);
  assign is_fb   = (addr[3:0] == FB_LOW_MATCH);

  assign sel_k   = TS_SEL_BASE - d;
  assign sel_hit = (sel_k < 8'(NUM_CHIPS));

  // No reset branch: a write spanning reset release must not look like a new event.
  always_ff @(posedge cpu_clock) io_wr_q <= io_wr;
  assign wr_event = io_wr && !io_wr_q;

  always_comb begin
    bus_next = BUS_INACTIVE;
    if (io_wr && is_fffd)
      bus_next = sel_hit ? BUS_INACTIVE : BUS_ADDR;
    else if (io_wr && is_bffd)
      bus_next = BUS_WRITE;
    else if (io_rd && is_fffd)
      bus_next = BUS_READ;
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      bdir         <= 1'b0;
      bc1          <= 1'b0;
      ioge         <= 1'b0;
      beeper       <= 1'b0;
      tapeout      <= 1'b0;
      covox_data   <= '0;
      covox_strobe <= 1'b0;
      div_q        <= 1'b0;
      sel_7m       <= 1'b0;
    end else begin
      {bdir, bc1}  <= bus_next;
      ioge         <= m1_n && ay_port && (!addr[14] || addr[13]);
      covox_strobe <= wr_event && is_fb;
      if (wr_event && is_fe) begin
        beeper  <= d[4];
        tapeout <= d[3];
      end
      if (wr_event && is_fb)
        covox_data <= d;
      div_q  <= !div_q;
      sel_7m <= clk_is_7m;
    end
  end

  generate
    if (NUM_CHIPS == 1) begin : g_single
      assign ym_sel_n = '0;
    end else begin : g_multi
      always_ff @(posedge cpu_clock) begin
        if (reset)
          ym_sel_n <= ~NUM_CHIPS'(1);
        else if (wr_event && is_fffd && sel_hit)
          for (int unsigned i = 0; i < NUM_CHIPS; i++)
            ym_sel_n[i] <= (sel_k != 8'(i));
      end
    end
  endgenerate

  assign ym_clock = sel_7m ? div_q : cpu_clock;

  ym_clk_detect #(
    .DETECT_THRESH(DETECT_THRESH),
    .CNT_W        (CNT_W)
  ) u_clk_detect (
    .cpu_clock(cpu_clock),
    .reset    (reset),
    .int_n    (int_n),
    .clk_is_7m(clk_is_7m)
  );

endmodule

// File: tb/tb_ym_bus_ctrl.sv
// Scoreboard bench for ym_bus_ctrl: four chips, detection threshold scaled
// down so frame measurements fit in a short run.
module tb_ym_bus_ctrl;

  logic        cpu_clock;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  d;
  logic        iorq_n, wr_n, rd_n, m1_n, int_n;
  logic        bdir, bc1;
  logic [3:0]  ym_sel_n;
  logic        ym_clock, clk_is_7m, ioge, beeper, tapeout;
  logic [7:0]  covox_data;
  logic        covox_strobe;

  ym_bus_ctrl #(
    .NUM_CHIPS    (4),
    .DETECT_THRESH(1500),
    .CNT_W        (11)
  ) dut (
    .cpu_clock   (cpu_clock),
    .reset       (reset),
    .addr        (addr),
    .d           (d),
    .iorq_n      (iorq_n),
    .wr_n        (wr_n),
    .rd_n        (rd_n),
    .m1_n        (m1_n),
    .int_n       (int_n),
    .bdir        (bdir),
    .bc1         (bc1),
    .ym_sel_n    (ym_sel_n),
    .ym_clock    (ym_clock),
    .clk_is_7m   (clk_is_7m),
    .ioge        (ioge),
    .beeper      (beeper),
    .tapeout     (tapeout),
    .covox_data  (covox_data),
    .covox_strobe(covox_strobe)
  );

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  typedef enum logic [2:0] {S_BUS, S_SEL, S_7M, S_IOGE, S_FE, S_COVOX, S_STROBE} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [15:0] observe(input sig_e s);
    case (s)
      S_BUS:    return {14'b0, bdir, bc1};
      S_SEL:    return {12'b0, ym_sel_n};
      S_7M:     return {15'b0, clk_is_7m};
      S_IOGE:   return {15'b0, ioge};
      S_FE:     return {14'b0, beeper, tapeout};
      S_COVOX:  return {8'b0, covox_data};
      S_STROBE: return {15'b0, covox_strobe};
      default:  return '0;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic idle();
    iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] v);
    addr = a; d = v; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic push_reset_state(input string tag);
    push({tag, "_bus"},    S_BUS,    16'h0);
    push({tag, "_sel"},    S_SEL,    16'hE);
    push({tag, "_7m"},     S_7M,     16'h0);
    push({tag, "_ioge"},   S_IOGE,   16'h0);
    push({tag, "_fe"},     S_FE,     16'h0);
    push({tag, "_covox"},  S_COVOX,  16'h0);
    push({tag, "_strobe"}, S_STROBE, 16'h0);
  endtask

  task automatic int_edge();
    int_n = 1'b0;
    tick();
    int_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1, a2;
    reset = 1'b1; addr = '0; d = '0; int_n = 1'b1;
    idle();
    tick(); tick();
    push_reset_state("rst");
    drain();
    reset = 1'b0;

    // AY address write, not a chip select
    io_wr(16'hFFFD, 8'h07); tick();
    push("addr_wr_bus", S_BUS, 16'h3); push("addr_wr_sel", S_SEL, 16'hE);
    push("addr_wr_ioge", S_IOGE, 16'h1); drain();
    idle(); tick();
    push("idle_bus", S_BUS, 16'h0); drain();

    // TurboSound selects
    io_wr(16'hFFFD, 8'hFE); tick();
    push("sel1_bus", S_BUS, 16'h0); push("sel1", S_SEL, 16'hD); drain();
    tick();
    push("sel1_hold_bus", S_BUS, 16'h0); push("sel1_hold", S_SEL, 16'hD); drain();
    idle(); tick();
    io_wr(16'hFFFD, 8'hFC); tick();
    push("sel3_bus", S_BUS, 16'h0); push("sel3", S_SEL, 16'h7); drain();
    idle(); tick();
    io_wr(16'hFFFD, 8'hFB); tick();
    push("fb_addr_bus", S_BUS, 16'h3); push("fb_addr_sel", S_SEL, 16'h7); drain();
    idle(); tick();

    // Data write, register read, BFFD read, M1 cycle
    io_wr(16'hBFFD, 8'h55); tick();
    push("data_wr_bus", S_BUS, 16'h2); push("data_wr_ioge", S_IOGE, 16'h1); drain();
    idle(); tick();
    addr = 16'hFFFD; iorq_n = 1'b0; rd_n = 1'b0; tick();
    push("rd_bus", S_BUS, 16'h1); drain();
    idle(); addr = 16'hBFFD; iorq_n = 1'b0; rd_n = 1'b0; tick();
    push("bffd_rd_bus", S_BUS, 16'h0); drain();
    idle(); tick();
    io_wr(16'hFFFD, 8'h07); m1_n = 1'b0; tick();
    push("m1_wr_bus", S_BUS, 16'h0); push("m1_wr_ioge", S_IOGE, 16'h0); drain();
    idle(); tick();

    // #FE held write: only the first cycle's data is latched
    io_wr(16'h00FE, 8'h18); tick();
    push("fe_first", S_FE, 16'h3); drain();
    d = 8'h00;
    repeat (3) begin
      tick();
      push("fe_held", S_FE, 16'h3); drain();
    end
    idle(); tick();
    io_wr(16'h00FE, 8'h10); tick();
    push("fe_second", S_FE, 16'h2); drain();
    idle(); tick();

    // #FB covox
    io_wr(16'h00FB, 8'hA5); tick();
    push("cvx_data", S_COVOX, 16'hA5); push("cvx_strobe", S_STROBE, 16'h1); drain();
    d = 8'h3C; tick();
    push("cvx_hold_data", S_COVOX, 16'hA5); push("cvx_hold_strobe", S_STROBE, 16'h0); drain();
    tick();
    push("cvx_hold2_strobe", S_STROBE, 16'h0); drain();
    idle(); tick();
    io_wr(16'h00FB, 8'h3C); tick();
    push("cvx2_data", S_COVOX, 16'h3C); push("cvx2_strobe", S_STROBE, 16'h1); drain();
    idle(); tick();
    push("cvx2_end_strobe", S_STROBE, 16'h0); drain();

    // IORQGE decode
    addr = 16'hBFFD; tick();
    push("ioge_bffd", S_IOGE, 16'h1); drain();
    addr = 16'hDFFD; tick();
    push("ioge_a13", S_IOGE, 16'h0); drain();
    addr = 16'hFFFD; m1_n = 1'b0; tick();
    push("ioge_m1", S_IOGE, 16'h0); drain();
    addr = 16'h7FFD; m1_n = 1'b1; tick();
    push("ioge_a15", S_IOGE, 16'h0); drain();

    // Reset during a held select write
    io_wr(16'hFFFD, 8'hFE); tick();
    push("pre_rst_sel", S_SEL, 16'hD); drain();
    reset = 1'b1; tick();
    push_reset_state("midrst");
    drain();
    reset = 1'b0; d = 8'hFD; tick();
    push("post_rst_sel", S_SEL, 16'hE); push("post_rst_bus", S_BUS, 16'h0);
    push("post_rst_ioge", S_IOGE, 16'h1); drain();
    d = 8'h07; tick();
    push("post_rst_hold_bus", S_BUS, 16'h3); push("post_rst_hold_sel", S_SEL, 16'hE); drain();
    idle(); addr = '0; tick();

    // Clock detection
    a0 = ym_clock; tick(); a1 = ym_clock;
    check_val("ymclk_pass0", {15'b0, a0}, 16'h1);
    check_val("ymclk_pass1", {15'b0, a1}, 16'h1);
    int_edge();
    push("det_first", S_7M, 16'h0); drain();
    repeat (2599) tick();
    int_edge();
    push("det_one_long", S_7M, 16'h0); drain();
    repeat (2599) tick();
    int_edge();
    push("det_two_long", S_7M, 16'h1); drain();
    tick();
    a0 = ym_clock; tick(); a1 = ym_clock; tick(); a2 = ym_clock;
    check_val("ymclk_div0", {15'b0, a0 ^ a1}, 16'h1);
    check_val("ymclk_div1", {15'b0, a1 ^ a2}, 16'h1);
    repeat (996) tick();
    int_edge();
    push("det_one_short", S_7M, 16'h1); drain();
    repeat (999) tick();
    int_edge();
    push("det_two_short", S_7M, 16'h0); drain();
    tick();
    a0 = ym_clock; tick(); a1 = ym_clock;
    check_val("ymclk_back0", {15'b0, a0}, 16'h1);
    check_val("ymclk_back1", {15'b0, a1}, 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
